// File: rtl/snake_step_sched.sv
// Snake move scheduler: tick generation, direction filter, step sequencer.
// Optional score-based speedup: define SNAKE_SPEEDUP_EN.
module snake_step_sched #(
  parameter int TICK_PERIOD = 25000000,
  parameter int MAX_SEGS    = 16,
  parameter int IDX_W       = 4,
  parameter int CNT_W       = 25,
  parameter int SPEED_STEP  = 2000000,
  parameter int MIN_PERIOD  = 5000000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       STATE,
  input  logic             BTN_UP,
  input  logic             BTN_RIGHT,
  input  logic             BTN_DOWN,
  input  logic             BTN_LEFT,
  input  logic [3:0]       SCORE_COUNT,
  output logic [1:0]       DIR,
  output logic             SHIFT_EN,
  output logic [IDX_W-1:0] SEG_IDX,
  output logic             HEAD_EN,
  output logic             STEP_DONE,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    S_WAIT, S_SHIFT, S_HEAD, S_DONE
  } state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(MAX_SEGS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_t st, nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] per_m1;
  logic [1:0] pend;
  logic [1:0] req;
  logic req_v, accept, play, tick;

  always_comb begin
    req   = 2'd0;
    req_v = 1'b1;
    if (BTN_UP)         req = 2'd0;
    else if (BTN_RIGHT) req = 2'd1;
    else if (BTN_DOWN)  req = 2'd2;
    else if (BTN_LEFT)  req = 2'd3;
    else                req_v = 1'b0;
  end

  // reversal is judged against the applied direction, not the pending one
  assign accept = req_v &&
    ((STATE == ST_IDLE) ||
     ((STATE == ST_PLAY) && (req != (DIR ^ 2'b10))));

  assign play = (STATE == ST_PLAY);
  assign tick = play && (st == S_WAIT) && (cnt == per_m1);

  always_comb begin
    nxt = st;
    unique case (st)
      S_WAIT:  if (tick) nxt = S_SHIFT;
      S_SHIFT: if (SEG_IDX == IDX_ONE) nxt = S_HEAD;
      S_HEAD:  nxt = S_DONE;
      S_DONE:  nxt = S_WAIT;
      default: nxt = S_WAIT;
    endcase
  end

`ifdef SNAKE_SPEEDUP_EN
  localparam int PW = CNT_W + 4;
  logic [PW-1:0] dec, per_w, per_nm1;

  always_comb begin
    dec = PW'(SCORE_COUNT) * PW'(SPEED_STEP);
    if (dec + PW'(MIN_PERIOD) >= PW'(TICK_PERIOD))
      per_w = PW'(MIN_PERIOD);
    else
      per_w = PW'(TICK_PERIOD) - dec;
    per_nm1 = per_w - PW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      per_m1 <= CNT_W'(TICK_PERIOD - 1);
    else if (st == S_DONE)
      per_m1 <= per_nm1[CNT_W-1:0];
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^SCORE_COUNT ^
    (SPEED_STEP != 0) ^ (MIN_PERIOD != 0);
  assign per_m1 = CNT_W'(TICK_PERIOD - 1);
`endif

  // outputs are registered from the next state so they align with it
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st        <= S_WAIT;
      cnt       <= '0;
      pend      <= 2'd1;
      DIR       <= 2'd1;
      SEG_IDX   <= '0;
      SHIFT_EN  <= 1'b0;
      HEAD_EN   <= 1'b0;
      STEP_DONE <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      st        <= nxt;
      SHIFT_EN  <= (nxt == S_SHIFT);
      HEAD_EN   <= (nxt == S_HEAD);
      STEP_DONE <= (nxt == S_DONE);
      BUSY      <= (nxt != S_WAIT);
      if (accept) pend <= req;
      if (tick) begin
        DIR     <= pend;
        SEG_IDX <= IDX_TOP;
      end else if ((st == S_SHIFT) && (SEG_IDX != IDX_ONE)) begin
        SEG_IDX <= SEG_IDX - IDX_ONE;
      end
      if (!play || tick || (st == S_DONE))
        cnt <= '0;
      else if (st == S_WAIT)
        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_snake_step_sched.sv
// Directed bench for snake_step_sched (TICK_PERIOD=10, MAX_SEGS=4).
module tb_snake_step_sched;

`ifdef SNAKE_SPEEDUP_EN
  localparam int TP = 100;
  localparam int CW = 7;
`else
  localparam int TP = 10;
  localparam int CW = 4;
`endif
  localparam int MS = 4;
  localparam int IW = 2;

  logic CLK, RESET;
  logic [1:0] STATE;
  logic BTN_UP, BTN_RIGHT, BTN_DOWN, BTN_LEFT;
  logic [3:0] SCORE_COUNT;
  logic [1:0] DIR;
  logic SHIFT_EN, HEAD_EN, STEP_DONE, BUSY;
  logic [IW-1:0] SEG_IDX;

  int tests = 0;
  int fails = 0;

  snake_step_sched #(
    .TICK_PERIOD(TP), .MAX_SEGS(MS), .IDX_W(IW),
    .CNT_W(CW), .SPEED_STEP(10), .MIN_PERIOD(40)
  ) dut (
    .CLK(CLK), .RESET(RESET), .STATE(STATE),
    .BTN_UP(BTN_UP), .BTN_RIGHT(BTN_RIGHT),
    .BTN_DOWN(BTN_DOWN), .BTN_LEFT(BTN_LEFT),
    .SCORE_COUNT(SCORE_COUNT), .DIR(DIR),
    .SHIFT_EN(SHIFT_EN), .SEG_IDX(SEG_IDX),
    .HEAD_EN(HEAD_EN), .STEP_DONE(STEP_DONE),
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic [1:0] st;
    logic       shift;
    logic [1:0] idx;
    logic       head;
    logic       done;
    logic       busy;
    logic [1:0] dir;
  } vec_t;

  vec_t tbl[31];

  task automatic tk();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_shift(input int lim, output int n);
    n = 0;
    do begin
      tk();
      n++;
    end while (!SHIFT_EN && n < lim);
    if (!SHIFT_EN) begin
      tests++;
      fails++;
      $display("FAIL wait_shift timeout actual=0 required=1");
    end
  endtask

  // from first SHIFT_EN cycle through STEP_DONE
  task automatic finish_step(input string nm);
    tk(); tk(); tk(); tk();
    chk({nm, "_done"}, {28'd0, STEP_DONE, HEAD_EN, SHIFT_EN, BUSY}, 32'h9);
  endtask

  function automatic vec_t mk(input logic s, input logic [1:0] i,
                              input logic h, input logic d,
                              input logic b);
    vec_t v;
    v.rst = 1'b0; v.st = 2'd1; v.shift = s; v.idx = i;
    v.head = h; v.done = d; v.busy = b; v.dir = 2'd1;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RESET = 1'b1; STATE = 2'd0; SCORE_COUNT = 4'd0;
    BTN_UP = 0; BTN_RIGHT = 0; BTN_DOWN = 0; BTN_LEFT = 0;
`ifndef SNAKE_SPEEDUP_EN
    tbl[0] = mk(0, 2'd0, 0, 0, 0);
    tbl[0].rst = 1'b1; tbl[0].st = 2'd0;
    for (int p = 1; p <= 30; p++)
      tbl[p] = mk(0, (p < 10) ? 2'd0 : 2'd1, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      int b;
      b = (k == 0) ? 10 : 25;
      tbl[b]   = mk(1, 2'd3, 0, 0, 1);
      tbl[b+1] = mk(1, 2'd2, 0, 0, 1);
      tbl[b+2] = mk(1, 2'd1, 0, 0, 1);
      tbl[b+3] = mk(0, 2'd1, 1, 0, 1);
      tbl[b+4] = mk(0, 2'd1, 0, 1, 1);
    end

    for (int p = 0; p <= 30; p++) begin
      RESET = tbl[p].rst;
      STATE = tbl[p].st;
      tk();
      chk($sformatf("vec%0d", p),
          {24'd0, SHIFT_EN, SEG_IDX, HEAD_EN, STEP_DONE, BUSY, DIR},
          {24'd0, tbl[p].shift, tbl[p].idx, tbl[p].head,
           tbl[p].done, tbl[p].busy, tbl[p].dir});
    end

    BTN_LEFT = 1; tk(); BTN_LEFT = 0;
    wait_shift(40, n);
    chk("rev_left_discard", DIR, 2'd1);
    finish_step("s3");

    BTN_LEFT = 1; tk(); BTN_LEFT = 0;
    BTN_UP = 1; tk(); BTN_UP = 0;
    wait_shift(40, n);
    chk("left_then_up", DIR, 2'd0);
    chk("spacing", n, 9);
    finish_step("s4");

    BTN_DOWN = 1; tk(); BTN_DOWN = 0;
    wait_shift(40, n);
    chk("rev_down_discard", DIR, 2'd0);
    finish_step("s5");

    BTN_RIGHT = 1; BTN_DOWN = 1; BTN_LEFT = 1; tk();
    BTN_RIGHT = 0; BTN_DOWN = 0; BTN_LEFT = 0;
    wait_shift(40, n);
    chk("priority_right", DIR, 2'd1);
    BTN_UP = 1;
    finish_step("s6");
    chk("dir_stable_midstep", DIR, 2'd1);
    BTN_UP = 0;

    STATE = 2'd0;
    BTN_LEFT = 1; tk(); BTN_LEFT = 0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tk();
      if (SHIFT_EN || BUSY) n++;
    end
    chk("idle_no_tick", n, 0);
    STATE = 2'd1;
    wait_shift(40, n);
    chk("idle_first_dir", DIR, 2'd3);
    chk("idle_first_lat", n, TP);

    tk();
    STATE = 2'd2;
    chk("win_idx2", {SHIFT_EN, SEG_IDX}, {1'b1, 2'd2});
    tk();
    chk("win_idx1", {SHIFT_EN, SEG_IDX}, {1'b1, 2'd1});
    tk();
    chk("win_head", {SHIFT_EN, HEAD_EN, STEP_DONE}, 3'b010);
    tk();
    chk("win_done", {SHIFT_EN, HEAD_EN, STEP_DONE, BUSY}, 4'b0011);
    BTN_DOWN = 1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tk();
      if (SHIFT_EN || HEAD_EN || STEP_DONE || BUSY) n++;
    end
    BTN_DOWN = 0;
    chk("win_no_tick", n, 0);
    STATE = 2'd1;
    wait_shift(40, n);
    chk("win_btn_ignored", DIR, 2'd3);
    chk("win_resume_lat", n, TP);

    tk();
    RESET = 1;
    tk();
    chk("reset_midstep",
        {SHIFT_EN, SEG_IDX, HEAD_EN, STEP_DONE, BUSY, DIR},
        {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1});
    RESET = 0;
    tk();
    chk("reset_stays_idle", {SHIFT_EN, BUSY}, 2'b00);
`else
    SCORE_COUNT = 4'd3;
    tk();
    RESET = 0; STATE = 2'd1;
    wait_shift(200, n);
    chk("sp_first", n, 100);
    finish_step("sp1");
    wait_shift(200, n);
    chk("sp_score3", n, 71);
    SCORE_COUNT = 4'd9;
    finish_step("sp2");
    wait_shift(200, n);
    chk("sp_score9_clamp", n, 41);
    finish_step("sp3");
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
